// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter: round-robin share of one in-order pipelined unit, tag FIFO routes results to owners.
// Optional feature macro SHARED_ARB_PERF_EN adds per-requester accept counters and a full-FIFO stall counter.
module shared_unit_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int PAY_W        = 576,
    parameter int RES_W        = 256,
    parameter int MAX_INFLIGHT = 4,
    parameter int PERF_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clk_en,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*PAY_W-1:0] i_req_payload_flat,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_unit_valid,
    output logic [PAY_W-1:0]         o_unit_payload,
    input  logic                     i_unit_o_valid,
    input  logic [RES_W-1:0]         i_unit_result,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    output logic [RES_W-1:0]         o_rsp_data,
    output logic                     o_busy,
    output logic                     o_err_orphan
`ifdef SHARED_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_W-1:0] o_grant_cnt_flat,
    output logic [PERF_W-1:0]         o_stall_cnt
`endif
);
    localparam int TW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;

    logic [TW-1:0]      rr_ptr;
    logic [TW-1:0]      gidx;
    logic [TW-1:0]      rr_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [PAY_W-1:0]   gpay;
    logic [TW-1:0]      tags [MAX_INFLIGHT];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               accept;
    logic               res_in;
    logic               pop;
    logic               orphan;
    int                 idx;

    // Round-robin scan from rr_ptr: first valid requester wins; also selects its payload
    always_comb begin
        grant = '0;
        gidx  = '0;
        gpay  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (grant == '0 && i_req_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = TW'(idx);
            end
        end
        for (int r = 0; r < NUM_REQ; r++)
            if (grant[r]) gpay = i_req_payload_flat[r*PAY_W +: PAY_W];
        rr_nxt = (gidx == TW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end

    // Full is judged on registered count only, so a same-cycle pop never opens a slot
    assign full        = count[CW-1];
    assign o_req_ready = (i_clk_en && !full) ? grant : '0;
    assign accept      = |o_req_ready;
    assign res_in      = i_unit_o_valid && i_clk_en;
    assign pop         = res_in && (count != '0);
    assign orphan      = res_in && (count == '0);
    assign o_busy      = (count != '0);

    // Issue register, tag FIFO pointers, response register and sticky orphan flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            o_unit_valid   <= 1'b0;
            o_unit_payload <= '0;
            o_rsp_valid    <= '0;
            o_rsp_data     <= '0;
            o_err_orphan   <= 1'b0;
        end else if (i_clk_en) begin
            o_unit_valid <= accept;
            o_rsp_valid  <= pop ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << tags[rd_ptr]) : '0;
            count        <= count + CW'(accept) - CW'(pop);
            if (accept) begin
                rr_ptr         <= rr_nxt;
                wr_ptr         <= wr_ptr + 1'b1;
                o_unit_payload <= gpay;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                o_rsp_data <= i_unit_result;
            end
            if (orphan) o_err_orphan <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (accept) tags[wr_ptr] <= gidx;
    end

`ifdef SHARED_ARB_PERF_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        // Saturating accept counter for requester g
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                o_grant_cnt_flat[g*PERF_W +: PERF_W] <= '0;
            else if (o_req_ready[g] && o_grant_cnt_flat[g*PERF_W +: PERF_W] != '1)
                o_grant_cnt_flat[g*PERF_W +: PERF_W] <= o_grant_cnt_flat[g*PERF_W +: PERF_W] + 1'b1;
        end
    end

    // Saturating count of cycles where requests wait only because the FIFO is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_stall_cnt <= '0;
        else if (i_clk_en && |i_req_valid && full && o_stall_cnt != '1)
            o_stall_cnt <= o_stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// tb_shared_unit_arbiter: directed and random stimulus checked against a queue-based reference model.
module tb_shared_unit_arbiter;
    localparam int N     = 3;
    localparam int PAY_W = 576;
    localparam int RES_W = 256;
    localparam int MAXF  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 clk_en = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N*PAY_W-1:0]   pay_flat = '0;
    logic                 unit_o_valid = 1'b0;
    logic [RES_W-1:0]     unit_result = '0;
    logic [N-1:0]         req_ready;
    logic                 unit_valid;
    logic [PAY_W-1:0]     unit_payload;
    logic [N-1:0]         rsp_valid;
    logic [RES_W-1:0]     rsp_data;
    logic                 busy;
    logic                 err_orphan;

    shared_unit_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_clk_en          (clk_en),
        .i_req_valid       (req_valid),
        .i_req_payload_flat(pay_flat),
        .o_req_ready       (req_ready),
        .o_unit_valid      (unit_valid),
        .o_unit_payload    (unit_payload),
        .i_unit_o_valid    (unit_o_valid),
        .i_unit_result     (unit_result),
        .o_rsp_valid       (rsp_valid),
        .o_rsp_data        (rsp_data),
        .o_busy            (busy),
        .o_err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int               rr;
    int               q[$];
    logic             m_uv;
    logic [PAY_W-1:0] m_pay;
    logic [N-1:0]     m_rv;
    logic [RES_W-1:0] m_rd;
    logic             m_orph;
    bit               a5_mode = 0;

    task automatic check(input string tag, input logic [PAY_W-1:0] got, input logic [PAY_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PAY_W-1:0] rand_pay();
        logic [PAY_W-1:0] p;
        for (int i = 0; i < PAY_W / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [RES_W-1:0] rand_res();
        logic [PAY_W-1:0] p;
        p = rand_pay();
        return p[RES_W-1:0];
    endfunction

    // Expected grant: first valid requester walking round-robin from rr, if enabled and not full
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] g;
        g = '0;
        if (clk_en && q.size() < MAXF)
            for (int i = 0; i < N; i++)
                if (g == '0 && req_valid[(rr + i) % N]) g[(rr + i) % N] = 1'b1;
        return g;
    endfunction

    task automatic model_clear();
        q.delete();
        rr     = 0;
        m_uv   = 1'b0;
        m_pay  = '0;
        m_rv   = '0;
        m_rd   = '0;
        m_orph = 1'b0;
    endtask

    // One clock: check registered outputs, drive inputs, check ready, advance model
    task automatic cyc(input logic [N-1:0] v, input logic en, input logic uo, input logic [RES_W-1:0] res);
        logic [N-1:0] rdy;
        int h;
        @(negedge clk);
        check("unit_valid", unit_valid, m_uv);
        check("unit_payload", unit_payload, m_pay);
        check("rsp_valid", rsp_valid, m_rv);
        check("rsp_data", rsp_data, m_rd);
        check("busy", busy, q.size() != 0);
        check("err_orphan", err_orphan, m_orph);
        req_valid    = v;
        clk_en       = en;
        unit_o_valid = uo;
        unit_result  = res;
        for (int r = 0; r < N; r++)
            pay_flat[r*PAY_W +: PAY_W] = a5_mode ? {(PAY_W/8){8'hA5}} : rand_pay();
        #1;
        rdy = model_ready();
        check("req_ready", req_ready, rdy);
        if (en) begin
            if (uo && q.size() > 0) begin
                h    = q.pop_front();
                m_rv = N'(1) << h;
                m_rd = res;
            end else begin
                m_rv = '0;
                if (uo) m_orph = 1'b1;
            end
            m_uv = (rdy != '0);
            for (int r = 0; r < N; r++)
                if (rdy[r]) begin
                    q.push_back(r);
                    rr    = (r + 1) % N;
                    m_pay = pay_flat[r*PAY_W +: PAY_W];
                end
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req_valid    = '0;
        clk_en       = 1'b0;
        unit_o_valid = 1'b0;
        #1;
        model_clear();
        check("rst_unit_valid", unit_valid, 0);
        check("rst_unit_payload", unit_payload, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Single request from requester 0, one result back
        a5_mode = 1;
        cyc(3'b001, 1, 0, '0);
        a5_mode = 0;
        cyc(3'b000, 1, 1, RES_W'(32'h1234));
        cyc(3'b000, 1, 0, '0);
        check("t1_rsp_owner", rsp_valid, 3'b001);
        check("t1_rsp_data", rsp_data, 32'h1234);
        cyc(3'b000, 1, 0, '0);

        // All requesters valid, unit returns two cycles after issue
        do_reset();
        for (int k = 0; k < 12; k++) cyc(3'b111, 1, q.size() >= 2, rand_res());
        for (int k = 0; k < 3; k++) cyc(3'b000, 1, q.size() > 0, rand_res());

        // Unit stalls: FIFO fills, then a single return frees one slot
        do_reset();
        for (int k = 0; k < 6; k++) cyc(3'b010, 1, 0, '0);
        check("t3_busy_full", busy, 1);
        cyc(3'b010, 1, 1, rand_res());
        cyc(3'b010, 1, 0, '0);
        check("t3_rsp_owner", rsp_valid, 3'b010);
        cyc(3'b010, 1, 0, '0);

        // Orphan result with empty FIFO stays flagged
        do_reset();
        cyc(3'b000, 1, 1, rand_res());
        for (int k = 0; k < 3; k++) cyc(3'b000, 1, 0, '0);
        check("t4_orphan_sticky", err_orphan, 1);

        // Clock-enable pause mid-stream
        do_reset();
        for (int k = 0; k < 16; k++) cyc(3'b111, !(k >= 5 && k < 10), q.size() >= 2, rand_res());

        // Reset with two in flight, later results become orphans
        do_reset();
        cyc(3'b101, 1, 0, '0);
        cyc(3'b101, 1, 0, '0);
        cyc(3'b000, 1, 0, '0);
        do_reset();
        cyc(3'b000, 1, 1, rand_res());
        cyc(3'b000, 1, 1, rand_res());
        cyc(3'b011, 1, 0, '0);
        check("t6_orphan_after_rst", err_orphan, 1);

        // Random traffic with periodic resets
        for (int k = 0; k < 2000; k++) begin
            if (k % 400 == 0) do_reset();
            cyc(N'($urandom), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 1) == 1) && (q.size() > 0 || $urandom_range(0, 49) == 0),
                rand_res());
        end
        cyc(3'b000, 1, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
